q_calc_arbiter: RTL and testbench
=================================

Q_CALC_ARBITER -- requirements
Module: q_calc_arbiter

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter TIMEOUT, 1024, max cycles from first core issue to core_Q_valid (range 2..65535).
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  bit i = requester i has a job pending.
REQ-006 req_ready  out  2  bit i = job of requester i accepted this cycle.
REQ-007 req_X, req_T, req_N, req_alpha  in  2*DATA_W each  requester i operand in bits [DATA_W*i +: DATA_W].
REQ-008 core_X, core_T, core_N, core_alpha  out  DATA_W each  operands to the shared Q-function core.
REQ-009 core_valid  out  4  per-channel valid; bit0 X, bit1 T, bit2 N, bit3 alpha.
REQ-010 core_ready  in  4  per-channel ready, same bit order.
REQ-011 core_Q, core_Q_valid  in  DATA_W, 1  core result and its one-cycle strobe.
REQ-012 resp_valid, resp_ready  out, in  1, 1  result handshake.
REQ-013 resp_id  out  1  requester the result belongs to.
REQ-014 resp_Q  out  DATA_W  result value.
REQ-015 resp_err  out  1  result produced by timeout, not by core.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-018 IDLE: if any req_valid bit set, grant one requester, register its four operands into core_*, pulse req_ready[grant] for exactly that cycle, go ISSUE.
REQ-019 Arbitration round-robin: requester not granted last wins a tie; pointer favours requester 0 after reset.
REQ-020 req_valid sampled only in IDLE; req_ready is 0 in every other state.
REQ-021 ISSUE: core_valid = 4'b1111 on entry; each bit clears the cycle after its own valid&ready handshake; channels complete independently and in any order.
REQ-022 core_X/T/N/alpha held stable from grant until the job returns to IDLE.
REQ-023 When the last outstanding channel handshakes, next state is WAIT (same-cycle handshake of all four goes straight to WAIT).
REQ-024 WAIT: on core_Q_valid register core_Q into resp_Q, resp_err=0, go RESP; core_Q_valid in IDLE/ISSUE/RESP ignored.
REQ-025 16-bit timeout counter clears on entry to ISSUE, increments each ISSUE/WAIT cycle; reaching TIMEOUT-1 without completion forces core_valid=0, resp_Q=all-ones, resp_err=1, go RESP.
REQ-026 core_Q_valid in the same cycle as timeout expiry: core result wins, resp_err=0.
REQ-027 RESP: resp_valid=1, resp_id=grant, resp_Q/resp_err stable until resp_ready; on handshake go IDLE and update arbitration pointer.
REQ-028 At least one IDLE cycle between jobs; no acceptance in the resp handshake cycle.
REQ-029 Latency with core_ready=4'hF and core_Q_valid L cycles after issue: req_ready cycle 0, core_valid cycle 1, resp_valid cycle L+2.

Reset
REQ-030 On aresetn low: state IDLE, all outputs 0 (core_* data, core_valid, req_ready, resp_*, busy), counter 0, pointer to requester 0.
REQ-031 Reset mid-job abandons it; a core_Q_valid arriving after release while in IDLE is discarded.

Structure
REQ-032 Shared package q_ctrl_pkg holds FSM state encoding, DATA_W default, channel bit indices (CH_X=0, CH_T=1, CH_N=2, CH_ALPHA=3).
REQ-033 One sub-module rr_arb2: 2-way round-robin grant with pointer update input.

Verification
REQ-034 Req0 only, X=5,T=7,N=3,alpha=2, core_ready=F, Q_valid 3 cycles after issue with Q=0x1234 -> req_ready[0] cycle 0, resp_valid cycle 5, resp_id=0, resp_Q=0x1234, resp_err=0.
REQ-035 Both requesters valid continuously, 4 jobs -> grants 0,1,0,1; each response id matches its operands.
REQ-036 core_ready bits asserted in order alpha, N, T, X one cycle apart -> each core_valid bit drops the cycle after its own handshake; WAIT entered after X.
REQ-037 TIMEOUT=8, core never asserts Q_valid -> resp_valid with resp_Q=0xFFFFFFFF, resp_err=1; next job proceeds normally.
REQ-038 resp_ready held low 10 cycles -> resp_* stable, req_ready stays 0 despite req_valid.
REQ-039 aresetn low during WAIT, then core_Q_valid after release -> all outputs 0, no response produced.

Source files
------------

// File: rtl/q_ctrl_pkg.sv
// Shared types and constants for the Q-function core arbiter.
// Holds the FSM encoding, default widths and core channel indices.
package q_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 16;
    localparam int NUM_CH     = 4;

    localparam int CH_X     = 0;
    localparam int CH_T     = 1;
    localparam int CH_N     = 2;
    localparam int CH_ALPHA = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Channels still waiting for their own handshake after this cycle.
    function automatic logic [NUM_CH-1:0] ch_left(
        input logic [NUM_CH-1:0] vld,
        input logic [NUM_CH-1:0] rdy
    );
        return vld & ~rdy;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only on an explicit update.
// After reset requester 0 wins a tie.
module rr_arb2 (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Requester favoured when both are pending.
    logic prio;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prio <= 1'b0;
        end else if (upd) begin
            prio <= ~upd_id;
        end
    end

    always_comb begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            gnt_id = prio;
        end else begin
            gnt_id = req[1];
        end
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/q_calc_arbiter.sv
// Shares one Q-function core between two requesters, one job at a time,
// with per-channel operand handshakes and a completion timeout.
module q_calc_arbiter
    import q_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DATA_W-1:0] req_X,
    input  logic [2*DATA_W-1:0] req_T,
    input  logic [2*DATA_W-1:0] req_N,
    input  logic [2*DATA_W-1:0] req_alpha,
    output logic [DATA_W-1:0] core_X,
    output logic [DATA_W-1:0] core_T,
    output logic [DATA_W-1:0] core_N,
    output logic [DATA_W-1:0] core_alpha,
    output logic [3:0]        core_valid,
    input  logic [3:0]        core_ready,
    input  logic [DATA_W-1:0] core_Q,
    input  logic              core_Q_valid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_Q,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic              gnt_id;
    logic [1:0]        arb_gnt;
    logic              arb_id;
    logic              accept;
    logic              tmo;
    logic              resp_fire;
    logic [NUM_CH-1:0] cv_left;

    rr_arb2 u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (req_valid),
        .upd     (resp_fire),
        .upd_id  (gnt_id),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id)
    );

    assign accept    = (state == ST_IDLE) && (req_valid != 2'b00);
    assign tmo       = (cnt == TMO_LAST);
    assign resp_fire = (state == ST_RESP) && resp_ready;
    assign cv_left   = ch_left(core_valid, core_ready);

    // Keep the grant pulse off while reset is held, even with requests up.
    assign req_ready = (accept && aresetn) ? arb_gnt : 2'b00;
    assign busy      = (state != ST_IDLE);
    assign resp_id   = gnt_id;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tmo) begin
                    state_n = ST_RESP;
                end else if (cv_left == '0) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_Q_valid || tmo) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            core_X     <= '0;
            core_T     <= '0;
            core_N     <= '0;
            core_alpha <= '0;
            core_valid <= '0;
            cnt        <= '0;
            gnt_id     <= 1'b0;
            resp_valid <= 1'b0;
            resp_Q     <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        core_X     <= arb_id ? req_X[2*DATA_W-1:DATA_W]
                                             : req_X[DATA_W-1:0];
                        core_T     <= arb_id ? req_T[2*DATA_W-1:DATA_W]
                                             : req_T[DATA_W-1:0];
                        core_N     <= arb_id ? req_N[2*DATA_W-1:DATA_W]
                                             : req_N[DATA_W-1:0];
                        core_alpha <= arb_id ? req_alpha[2*DATA_W-1:DATA_W]
                                             : req_alpha[DATA_W-1:0];
                        core_valid <= '1;
                        cnt        <= '0;
                        gnt_id     <= arb_id;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (tmo) begin
                        core_valid <= '0;
                        resp_valid <= 1'b1;
                        resp_Q     <= '1;
                        resp_err   <= 1'b1;
                    end else begin
                        core_valid <= cv_left;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A result landing on the expiry cycle still counts.
                    if (core_Q_valid) begin
                        resp_valid <= 1'b1;
                        resp_Q     <= core_Q;
                        resp_err   <= 1'b0;
                    end else if (tmo) begin
                        resp_valid <= 1'b1;
                        resp_Q     <= '1;
                        resp_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    core_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_calc_arbiter.sv
// Scoreboard bench for q_calc_arbiter: directed latency/timeout/reset cases
// followed by randomized two-requester traffic against a reference model.
module tb_q_calc_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_X, req_T, req_N, req_alpha;
    logic [DW-1:0]   core_X, core_T, core_N, core_alpha;
    logic [3:0]      core_valid;
    logic [3:0]      core_ready;
    logic [DW-1:0]   core_Q;
    logic            core_Q_valid;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_id;
    logic [DW-1:0]   resp_Q;
    logic            resp_err;
    logic            busy;

    logic            rv [2];
    logic [DW-1:0]   xr [2];
    logic [DW-1:0]   tr [2];
    logic [DW-1:0]   nr [2];
    logic [DW-1:0]   ar [2];

    assign req_valid = {rv[1], rv[0]};
    assign req_X     = {xr[1], xr[0]};
    assign req_T     = {tr[1], tr[0]};
    assign req_N     = {nr[1], nr[0]};
    assign req_alpha = {ar[1], ar[0]};

    q_calc_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_X        (req_X),
        .req_T        (req_T),
        .req_N        (req_N),
        .req_alpha    (req_alpha),
        .core_X       (core_X),
        .core_T       (core_T),
        .core_N       (core_N),
        .core_alpha   (core_alpha),
        .core_valid   (core_valid),
        .core_ready   (core_ready),
        .core_Q       (core_Q),
        .core_Q_valid (core_Q_valid),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_Q       (resp_Q),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] expq0 [$];
    logic [32:0] expq1 [$];
    bit          auto_core = 1'b0;
    bit          last_gnt  = 1'b1;

    function automatic logic [31:0] f_q(input logic [31:0] x, t, n, a);
        return x * t + (n ^ a);
    endfunction

    // Reference: a job whose X ends in 4'hF is never answered by the core.
    function automatic logic [32:0] expect_of(input logic [31:0] x, t, n, a);
        if (x[3:0] == 4'hF) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, f_q(x, t, n, a)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ops"}, {core_X, core_T, core_N, core_alpha}, '0);
        chk({nm, "_ctl"}, {core_valid, req_ready, resp_valid, resp_id,
                           resp_err, busy, resp_Q}, '0);
    endtask

    task automatic push(input int i, input logic [32:0] e);
        if (i == 0) expq0.push_back(e);
        else        expq1.push_back(e);
    endtask

    task automatic monitor();
        bit          stall = 1'b0;
        logic [34:0] held  = '0;
        logic [32:0] e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall    = 1'b0;
                last_gnt = 1'b1;
                continue;
            end
            if (stall) begin
                chk("resp_hold", {resp_valid, resp_id, resp_err, resp_Q}, held);
            end
            stall = resp_valid && !resp_ready;
            held  = {resp_valid, resp_id, resp_err, resp_Q};
            if (resp_valid && resp_ready) begin
                if ((resp_id ? expq1.size() : expq0.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp id=%0d q=%0h err=%0d",
                             resp_id, resp_Q, resp_err);
                end else begin
                    e = resp_id ? expq1.pop_front() : expq0.pop_front();
                    chk("resp_data", {resp_err, resp_Q}, e);
                end
            end
            if (req_ready != 2'b00) begin
                chk("grant_legal", {busy, $onehot(req_ready),
                                    (req_ready & ~req_valid) == 2'b00}, 3'b011);
                if (req_valid == 2'b11) begin
                    chk("rr_grant", req_ready, last_gnt ? 2'b01 : 2'b10);
                end
                last_gnt = req_ready[1];
            end
        end
    endtask

    task automatic core_model();
        int k    = 0;
        int d    = -1;
        bit done = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (auto_core) begin
                resp_ready = ($urandom_range(0, 3) != 0);
                core_Q     = $urandom;
                if (!busy) begin
                    k = 0;
                    d = -1;
                    done = 1'b0;
                    core_ready   = 4'($urandom);
                    core_Q_valid = ($urandom_range(0, 5) == 0);
                end else if (resp_valid) begin
                    core_ready   = 4'($urandom);
                    core_Q_valid = ($urandom_range(0, 2) == 0);
                end else if (core_valid != 4'h0) begin
                    k++;
                    core_ready   = (k >= 3) ? 4'hF : 4'($urandom);
                    core_Q_valid = ($urandom_range(0, 4) == 0);
                end else begin
                    core_ready   = 4'($urandom);
                    core_Q_valid = 1'b0;
                    if (d < 0) d = $urandom_range(0, 2);
                    if (!done && d == 0 && core_X[3:0] != 4'hF) begin
                        core_Q_valid = 1'b1;
                        core_Q = f_q(core_X, core_T, core_N, core_alpha);
                        done   = 1'b1;
                    end else if (d > 0) begin
                        d--;
                    end
                end
            end
        end
    endtask

    // One directed job; per-cycle core_ready and core_valid given as nibbles.
    task automatic job(input int i, input logic [127:0] ops,
                       input logic [47:0] rdy, input int qs, input int qc,
                       input logic [31:0] qv, input int rc,
                       input logic [32:0] e, input logic [47:0] cvx);
        push(i, e);
        resp_ready = 1'b1;
        {xr[i], tr[i], nr[i], ar[i]} = ops;
        rv[i]        = 1'b1;
        core_ready   = rdy[3:0];
        core_Q_valid = 1'b0;
        core_Q       = '0;
        for (int c = 0; c <= rc + 1; c++) begin
            @(negedge aclk);
            if (c == 0) chk("req_ready", req_ready, 2'b01 << i);
            if (c == 1) chk("core_ops", {core_X, core_T, core_N, core_alpha}, ops);
            if (c < 12) chk("core_valid", core_valid, cvx[4*c +: 4]);
            chk("resp_valid_t", resp_valid, c == rc);
            @(posedge aclk);
            #1;
            rv[i]        = 1'b0;
            core_ready   = (c + 1 < 12) ? rdy[4*(c+1) +: 4] : 4'h0;
            core_Q_valid = (c + 1 == qc) || (c + 1 == qs);
            core_Q       = (c + 1 == qc) ? qv : 32'h0000_0BAD;
        end
        core_ready = 4'h0;
    endtask

    task automatic stall_test();
        push(1, {1'b0, 32'hCAFE});
        resp_ready = 1'b0;
        {xr[1], tr[1], nr[1], ar[1]} = {32'd11, 32'd12, 32'd13, 32'd14};
        rv[1]      = 1'b1;
        core_ready = 4'hF;
        for (int c = 0; c <= 14; c++) begin
            @(negedge aclk);
            if (c >= 3 && c <= 12) begin
                chk("stall_resp_valid", resp_valid, 1'b1);
                chk("stall_req_ready", req_ready, 2'b00);
            end
            if (c == 13) chk("stall_release", resp_valid, 1'b1);
            if (c == 14) chk("stall_done", {resp_valid, busy}, 2'b00);
            @(posedge aclk);
            #1;
            rv[1]        = 1'b0;
            rv[0]        = (c + 1 >= 2) && (c + 1 <= 12);
            core_Q_valid = (c + 1 == 2);
            core_Q       = 32'hCAFE;
            resp_ready   = (c + 1 == 13);
        end
        core_ready = 4'h0;
    endtask

    task automatic reset_test();
        resp_ready = 1'b1;
        core_ready = 4'hF;
        {xr[0], tr[0], nr[0], ar[0]} = {32'd21, 32'd22, 32'd23, 32'd24};
        rv[0] = 1'b1;
        @(posedge aclk);
        #1;
        rv[0] = 1'b0;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        chk("rst_pre_busy", {busy, core_valid}, 5'b10000);
        aresetn = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge aclk);
        chk_zero("rst_hold");
        @(posedge aclk);
        #1;
        aresetn      = 1'b1;
        core_Q_valid = 1'b1;
        core_Q       = 32'h99;
        @(posedge aclk);
        #1;
        core_Q_valid = 1'b0;
        core_ready   = 4'h0;
        repeat (6) begin
            @(negedge aclk);
            chk("post_rst_idle", {resp_valid, busy}, 2'b00);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic drv(input int i, input int n);
        int t;
        bit got;
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge aclk);
                #1;
            end
            xr[i] = $urandom;
            tr[i] = $urandom;
            nr[i] = $urandom;
            ar[i] = $urandom;
            if ($urandom_range(0, 5) == 0) xr[i][3:0] = 4'hF;
            push(i, expect_of(xr[i], tr[i], nr[i], ar[i]));
            rv[i] = 1'b1;
            t   = 0;
            got = 1'b0;
            while (!got && t < 100) begin
                @(negedge aclk);
                got = req_ready[i];
                @(posedge aclk);
                #1;
                t++;
            end
            rv[i] = 1'b0;
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL grant_timeout req=%0d actual=none required=grant", i);
            end
        end
    endtask

    task automatic main_seq();
        aresetn      = 1'b0;
        rv[0]        = 1'b0;
        rv[1]        = 1'b0;
        xr[0] = '0; xr[1] = '0; tr[0] = '0; tr[1] = '0;
        nr[0] = '0; nr[1] = '0; ar[0] = '0; ar[1] = '0;
        core_ready   = 4'h0;
        core_Q       = '0;
        core_Q_valid = 1'b0;
        resp_ready   = 1'b0;
        repeat (2) @(negedge aclk);
        chk_zero("reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        job(0, {32'd5, 32'd7, 32'd3, 32'd2}, {12{4'hF}}, -1, 4,
            32'h1234, 5, {1'b0, 32'h1234}, 48'h0F0);
        stall_test();
        job(0, {32'd1, 32'd2, 32'd3, 32'd4}, 48'h0000_0001_2480, 4, 5,
            32'h55, 6, {1'b0, 32'h55}, 48'h0000_0001_37F0);
        job(1, {32'd9, 32'd9, 32'd9, 32'd9}, {12{4'hF}}, -1, -1,
            32'h0, 9, {1'b1, 32'hFFFF_FFFF}, 48'h0F0);
        job(0, {32'd6, 32'd6, 32'd6, 32'd6}, {12{4'hF}}, -1, 8,
            32'h77, 9, {1'b0, 32'h77}, 48'h0F0);
        job(1, {32'd8, 32'd8, 32'd8, 32'd8}, 48'h0, -1, -1,
            32'h0, 9, {1'b1, 32'hFFFF_FFFF}, 48'h000F_FFFF_FFF0);
        reset_test();

        auto_core = 1'b1;
        fork
            drv(0, 25);
            drv(1, 25);
        join
        for (int t = 0; t < 300 && (expq0.size() + expq1.size()) != 0; t++) begin
            @(posedge aclk);
        end
        chk("sb_empty", expq0.size() + expq1.size(), 0);
        auto_core = 1'b0;
    endtask

    initial begin
        fork
            monitor();
            core_model();
            main_seq();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
